// File: rtl/kanade_mem_arbiter.sv
// kanade_mem_arbiter: N-channel arbiter in front of a single-port system RAM.
// Picks one requester per cycle (round-robin or fixed priority), drives the RAM
// with lane-shifted store data and byte enables, flags misaligned accesses and
// returns aligned, zero/sign-extended load data one cycle after the grant.
module kanade_mem_arbiter #(
  parameter int NUM_CH    = 2,
  parameter int ADDR_W    = 32,
  parameter int PRIO_MODE = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH-1:0]        ch_we,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*32-1:0]     ch_wdata,
  input  logic [NUM_CH*3-1:0]      ch_mode,
  output logic [NUM_CH-1:0]        ch_gnt,
  output logic [NUM_CH-1:0]        ch_rvalid,
  output logic [NUM_CH-1:0]        ch_err,
  output logic [31:0]              ch_rdata,
  output logic [ADDR_W-3:0]        mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_byteen,
  output logic                     mem_wren,
  input  logic [31:0]              mem_q
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // Access-mode encodings; anything outside 1..4 is a word access.
  localparam logic [2:0] MODE_BYTE_U = 3'd1;
  localparam logic [2:0] MODE_BYTE_S = 3'd2;
  localparam logic [2:0] MODE_HALF_U = 3'd3;
  localparam logic [2:0] MODE_HALF_S = 3'd4;

  // Per-channel views of the flattened request buses.
  logic [ADDR_W-1:0] addr_a  [NUM_CH];
  logic [31:0]       wdata_a [NUM_CH];
  logic [2:0]        mode_a  [NUM_CH];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign addr_a[gi]  = ch_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_a[gi] = ch_wdata[gi*32 +: 32];
      assign mode_a[gi]  = ch_mode[gi*3 +: 3];
    end
  endgenerate

  logic [IDX_W-1:0]  last_gnt_reg;
  logic              gnt_found;
  logic [IDX_W-1:0]  gnt_idx;

  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic [2:0]        sel_mode;
  logic              sel_we;
  logic              sel_aligned;
  logic [3:0]        sel_byteen;
  logic [31:0]       sel_wshift;

  logic [NUM_CH-1:0] rvalid_reg, rvalid_next;
  logic [NUM_CH-1:0] err_reg, err_next;
  logic [1:0]        rsp_off_reg;
  logic [2:0]        rsp_mode_reg;
  logic [31:0]       rdata_hold_reg;
  logic [31:0]       rdata_ext;

  // Pick the winning channel; round-robin starts one past the last winner.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    if (reset_n) begin
      if (PRIO_MODE == 1) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (!gnt_found && ch_req[i]) begin
            gnt_found = 1'b1;
            gnt_idx   = IDX_W'(i);
          end
        end
      end else begin
        for (int off = 1; off <= NUM_CH; off++) begin
          if (!gnt_found && ch_req[(int'(last_gnt_reg) + off) % NUM_CH]) begin
            gnt_found = 1'b1;
            gnt_idx   = IDX_W'((int'(last_gnt_reg) + off) % NUM_CH);
          end
        end
      end
    end
  end

  assign sel_addr  = addr_a[gnt_idx];
  assign sel_wdata = wdata_a[gnt_idx];
  assign sel_mode  = mode_a[gnt_idx];
  assign sel_we    = ch_we[gnt_idx];

  // Decode size of the selected access: alignment, byte enables, lane shift.
  always_comb begin
    sel_aligned = (sel_addr[1:0] == 2'b00);
    sel_byteen  = 4'b1111;
    sel_wshift  = sel_wdata;
    case (sel_mode)
      MODE_BYTE_U, MODE_BYTE_S: begin
        sel_aligned = 1'b1;
        sel_byteen  = 4'b0001 << sel_addr[1:0];
        sel_wshift  = sel_wdata << {sel_addr[1:0], 3'b000};
      end
      MODE_HALF_U, MODE_HALF_S: begin
        sel_aligned = ~sel_addr[0];
        sel_byteen  = 4'b0011 << {sel_addr[1], 1'b0};
        sel_wshift  = sel_wdata << {sel_addr[1], 4'b0000};
      end
      default: ;
    endcase
  end

  // Drive the RAM port and the grant vector; idle port reads word 0.
  always_comb begin
    ch_gnt     = '0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_byteen = 4'b1111;
    mem_wren   = 1'b0;
    if (gnt_found) begin
      ch_gnt[gnt_idx] = 1'b1;
      mem_addr        = sel_addr[ADDR_W-1:2];
      mem_wdata       = sel_wshift;
      mem_byteen      = sel_byteen;
      mem_wren        = sel_we & sel_aligned;
    end
  end

  // Next-cycle response pulses: error for misaligned, rvalid for aligned loads.
  always_comb begin
    rvalid_next = '0;
    err_next    = '0;
    if (gnt_found) begin
      if (!sel_aligned) begin
        err_next[gnt_idx] = 1'b1;
      end else if (!sel_we) begin
        rvalid_next[gnt_idx] = 1'b1;
      end
    end
  end

  // Round-robin pointer advances only on cycles that grant.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_gnt_reg <= IDX_W'(NUM_CH - 1);
    end else if (gnt_found) begin
      last_gnt_reg <= gnt_idx;
    end
  end

  // Response pipeline stage: remember who loaded, from which lane, in which mode.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rvalid_reg   <= '0;
      err_reg      <= '0;
      rsp_off_reg  <= '0;
      rsp_mode_reg <= '0;
    end else begin
      rvalid_reg <= rvalid_next;
      err_reg    <= err_next;
      if (|rvalid_next) begin
        rsp_off_reg  <= sel_addr[1:0];
        rsp_mode_reg <= sel_mode;
      end
    end
  end

  // Extract and extend the addressed lane(s) of the RAM word.
  always_comb begin
    logic [31:0] q_b;
    logic [31:0] q_h;
    q_b = mem_q >> {rsp_off_reg, 3'b000};
    q_h = mem_q >> {rsp_off_reg[1], 4'b0000};
    case (rsp_mode_reg)
      MODE_BYTE_U: rdata_ext = {24'h0, q_b[7:0]};
      MODE_BYTE_S: rdata_ext = {{24{q_b[7]}}, q_b[7:0]};
      MODE_HALF_U: rdata_ext = {16'h0, q_h[15:0]};
      MODE_HALF_S: rdata_ext = {{16{q_h[15]}}, q_h[15:0]};
      default:     rdata_ext = mem_q;
    endcase
  end

  // Keep the last delivered load value visible while no response is active.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rdata_hold_reg <= '0;
    end else if (|rvalid_reg) begin
      rdata_hold_reg <= rdata_ext;
    end
  end

  assign ch_rvalid = rvalid_reg;
  assign ch_err    = err_reg;
  assign ch_rdata  = (|rvalid_reg) ? rdata_ext : rdata_hold_reg;

endmodule

// File: tb/tb_kanade_mem_arbiter.sv
// Bench for kanade_mem_arbiter: 3-channel round-robin DUT on a byte-enabled RAM,
// plus a fixed-priority twin whose grants are checked on the same requests.
module tb_kanade_mem_arbiter;
  localparam int NCH = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n;
  logic [NCH-1:0]   ch_req, ch_we;
  logic [NCH*32-1:0] ch_addr, ch_wdata;
  logic [NCH*3-1:0] ch_mode;
  logic [NCH-1:0]   ch_gnt, ch_rvalid, ch_err;
  logic [31:0]      ch_rdata, mem_wdata, mem_q;
  logic [29:0]      mem_addr;
  logic [3:0]       mem_byteen;
  logic             mem_wren;

  logic [NCH-1:0]   p_gnt, p_rvalid, p_err;
  logic [31:0]      p_rdata, p_wdata;
  logic [29:0]      p_addr;
  logic [3:0]       p_byteen;
  logic             p_wren;
  logic [31:0]      p_q;
  assign p_q = 32'h0;

  kanade_mem_arbiter #(.NUM_CH(NCH), .ADDR_W(32), .PRIO_MODE(0)) dut (
    .clk(clk), .reset_n(reset_n), .ch_req(ch_req), .ch_we(ch_we),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_mode(ch_mode),
    .ch_gnt(ch_gnt), .ch_rvalid(ch_rvalid), .ch_err(ch_err), .ch_rdata(ch_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_byteen(mem_byteen),
    .mem_wren(mem_wren), .mem_q(mem_q));

  kanade_mem_arbiter #(.NUM_CH(NCH), .ADDR_W(32), .PRIO_MODE(1)) dut_prio (
    .clk(clk), .reset_n(reset_n), .ch_req(ch_req), .ch_we(ch_we),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_mode(ch_mode),
    .ch_gnt(p_gnt), .ch_rvalid(p_rvalid), .ch_err(p_err), .ch_rdata(p_rdata),
    .mem_addr(p_addr), .mem_wdata(p_wdata), .mem_byteen(p_byteen),
    .mem_wren(p_wren), .mem_q(p_q));

  // RAM: 64 words, synchronous read, byte-enabled write.
  logic [31:0] ram [0:63] = '{default: 32'h0};
  logic [31:0] wmerge;
  always_comb begin
    wmerge = ram[mem_addr[5:0]];
    for (int k = 0; k < 4; k++)
      if (mem_byteen[k]) wmerge[8*k +: 8] = mem_wdata[8*k +: 8];
  end
  always @(posedge clk) begin
    if (mem_wren) ram[mem_addr[5:0]] <= wmerge;
    mem_q <= ram[mem_addr[5:0]];
  end

  // Reference model state: byte-addressed memory and pending responses.
  logic [7:0]  ref_mem [0:255] = '{default: 8'h0};
  int          last_g;
  logic [2:0]  pend_rv, pend_err;
  logic [31:0] pend_rdata, last_rdata;
  int          tests, fails;

  // Requester inputs for the next cycle.
  logic [2:0]  in_req, in_we;
  logic [31:0] in_addr [NCH];
  logic [31:0] in_wdata [NCH];
  logic [2:0]  in_mode [NCH];

  // Snapshots of what the DUT showed in the last stepped cycle.
  logic [2:0]  snap_gnt, snap_pgnt, snap_rv, snap_err;
  logic [31:0] snap_rdata, snap_wdata;
  logic [3:0]  snap_byteen;
  logic        snap_wren;

  function automatic int size_of(input logic [2:0] m);
    if (m == 3'd1 || m == 3'd2) return 1;
    if (m == 3'd3 || m == 3'd4) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] a, input logic [2:0] m);
    logic [31:0] v;
    int sz;
    sz = size_of(m);
    v = 0;
    for (int j = 0; j < sz; j++) v = v | (32'(ref_mem[a[7:0] + 8'(j)]) << (8 * j));
    if (m == 3'd2 && v[7])  v = v | 32'hFFFF_FF00;
    if (m == 3'd4 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic step(input bit rst_lo, input bit rst_edge);
    int g, gp, sz, lane;
    logic [31:0] a, ew, mask;
    logic [3:0] eb;
    bit al;
    reset_n = !rst_lo;
    ch_req = in_req;
    ch_we  = in_we;
    for (int i = 0; i < NCH; i++) begin
      ch_addr[32*i +: 32]  = in_addr[i];
      ch_wdata[32*i +: 32] = in_wdata[i];
      ch_mode[3*i +: 3]    = in_mode[i];
    end
    #1;
    g = -1;
    gp = -1;
    if (!rst_lo) begin
      for (int off = 1; off <= NCH; off++)
        if (g < 0 && in_req[(last_g + off) % NCH]) g = (last_g + off) % NCH;
      for (int i = 0; i < NCH; i++)
        if (gp < 0 && in_req[i]) gp = i;
    end
    chk("gnt_rr", 32'(ch_gnt), (g >= 0) ? (32'd1 << g) : 32'd0);
    chk("gnt_prio", 32'(p_gnt), (gp >= 0) ? (32'd1 << gp) : 32'd0);
    chk("rvalid", 32'(ch_rvalid), 32'(pend_rv));
    chk("err", 32'(ch_err), 32'(pend_err));
    chk("rdata", ch_rdata, (pend_rv != 0) ? pend_rdata : last_rdata);
    snap_gnt = ch_gnt; snap_pgnt = p_gnt; snap_rv = ch_rvalid; snap_err = ch_err;
    snap_rdata = ch_rdata; snap_wdata = mem_wdata; snap_byteen = mem_byteen; snap_wren = mem_wren;
    al = 1'b1;
    a = 0;
    if (g < 0) begin
      chk("idle_wren", 32'(mem_wren), 32'd0);
      chk("idle_byteen", 32'(mem_byteen), 32'hF);
      chk("idle_addr", 32'(mem_addr), 32'd0);
    end else begin
      a  = in_addr[g];
      sz = size_of(in_mode[g]);
      al = (a % sz) == 0;
      chk("mem_addr", 32'(mem_addr), a >> 2);
      chk("wren", 32'(mem_wren), 32'(in_we[g] && al));
      if (in_we[g] && al) begin
        eb = 0; ew = 0; mask = 0;
        for (int j = 0; j < sz; j++) begin
          lane = int'(a % 4) + j;
          eb[lane] = 1'b1;
          ew[8*lane +: 8] = in_wdata[g][8*j +: 8];
          mask[8*lane +: 8] = 8'hFF;
        end
        chk("byteen", 32'(mem_byteen), 32'(eb));
        chk("wdata", mem_wdata & mask, ew);
      end
    end
    if (pend_rv != 0) last_rdata = pend_rdata;
    pend_rv = 0;
    pend_err = 0;
    if (g >= 0) begin
      last_g = g;
      if (!al) pend_err = 3'(1 << g);
      else if (in_we[g]) begin
        if (!rst_edge)
          for (int j = 0; j < sz; j++) ref_mem[a[7:0] + 8'(j)] = in_wdata[g][8*j +: 8];
      end else begin
        pend_rv = 3'(1 << g);
        pend_rdata = load_val(a, in_mode[g]);
      end
    end
    if (rst_lo || rst_edge) begin
      reset_n = 1'b0;
      last_g = NCH - 1;
      pend_rv = 0;
      pend_err = 0;
      last_rdata = 0;
    end
    @(negedge clk);
  endtask

  typedef struct {
    int          ch;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  mode;
    logic [3:0]  exp_byteen;
    logic [31:0] exp_wdata;
    bit          exp_wren;
    bit          exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [14];
  logic [2:0] rr_exp [6];

  task automatic set_single(input int ch, input bit we, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [2:0] m);
    in_req = 3'(1 << ch);
    in_we = 0;
    in_we[ch] = we;
    for (int i = 0; i < NCH; i++) begin
      in_addr[i] = 0; in_wdata[i] = 0; in_mode[i] = 0;
    end
    in_addr[ch] = addr; in_wdata[ch] = wd; in_mode[ch] = m;
  endtask

  initial begin
    vecs[0]  = '{0, 1, 32'h10, 32'hDEADBEEF, 3'd0, 4'hF, 32'hDEADBEEF, 1, 0, 32'h0};
    vecs[1]  = '{1, 0, 32'h10, 32'h0,        3'd0, 4'hF, 32'h0,        0, 0, 32'hDEADBEEF};
    vecs[2]  = '{0, 1, 32'h13, 32'h000000A5, 3'd1, 4'b1000, 32'hA5000000, 1, 0, 32'h0};
    vecs[3]  = '{1, 0, 32'h13, 32'h0,        3'd2, 4'hF, 32'h0,        0, 0, 32'hFFFFFFA5};
    vecs[4]  = '{1, 0, 32'h13, 32'h0,        3'd1, 4'hF, 32'h0,        0, 0, 32'h000000A5};
    vecs[5]  = '{0, 1, 32'h22, 32'h00008001, 3'd3, 4'b1100, 32'h80010000, 1, 0, 32'h0};
    vecs[6]  = '{2, 0, 32'h22, 32'h0,        3'd4, 4'hF, 32'h0,        0, 0, 32'hFFFF8001};
    vecs[7]  = '{1, 0, 32'h20, 32'h0,        3'd0, 4'hF, 32'h0,        0, 0, 32'h80010000};
    vecs[8]  = '{0, 0, 32'h11, 32'h0,        3'd0, 4'hF, 32'h0,        0, 1, 32'h0};
    vecs[9]  = '{2, 1, 32'h05, 32'h00001234, 3'd3, 4'hF, 32'h0,        0, 1, 32'h0};
    vecs[10] = '{1, 0, 32'h04, 32'h0,        3'd0, 4'hF, 32'h0,        0, 0, 32'h0};
    vecs[11] = '{0, 1, 32'h30, 32'h11223344, 3'd7, 4'hF, 32'h11223344, 1, 0, 32'h0};
    vecs[12] = '{2, 0, 32'h31, 32'h0,        3'd1, 4'hF, 32'h0,        0, 0, 32'h00000033};
    vecs[13] = '{2, 0, 32'h32, 32'h0,        3'd4, 4'hF, 32'h0,        0, 0, 32'h00001122};
    rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    tests = 0; fails = 0;
    last_g = NCH - 1; pend_rv = 0; pend_err = 0; pend_rdata = 0; last_rdata = 0;
    set_single(0, 0, 0, 0, 0);
    in_req = 0;
    reset_n = 1'b0;
    ch_req = 0; ch_we = 0; ch_addr = 0; ch_wdata = 0; ch_mode = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Idle cycle right after reset: all outputs at reset/idle values.
    step(0, 0);

    // Directed single-channel transactions, each followed by an idle cycle.
    for (int v = 0; v < 14; v++) begin
      set_single(vecs[v].ch, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].mode);
      step(0, 0);
      chk($sformatf("v%0d_gnt", v), 32'(snap_gnt), 32'd1 << vecs[v].ch);
      chk($sformatf("v%0d_wren", v), 32'(snap_wren), 32'(vecs[v].exp_wren));
      if (vecs[v].exp_wren) begin
        chk($sformatf("v%0d_byteen", v), 32'(snap_byteen), 32'(vecs[v].exp_byteen));
        chk($sformatf("v%0d_wdata", v), snap_wdata, vecs[v].exp_wdata);
      end
      in_req = 0;
      step(0, 0);
      chk($sformatf("v%0d_err", v), 32'(snap_err), vecs[v].exp_err ? (32'd1 << vecs[v].ch) : 32'd0);
      chk($sformatf("v%0d_rvalid", v), 32'(snap_rv),
          (!vecs[v].we && !vecs[v].exp_err) ? (32'd1 << vecs[v].ch) : 32'd0);
      if (!vecs[v].we && !vecs[v].exp_err)
        chk($sformatf("v%0d_rdata", v), snap_rdata, vecs[v].exp_rdata);
    end

    // Fresh reset, then all three request every cycle: rotating grants.
    in_req = 0;
    step(1, 0);
    for (int i = 0; i < NCH; i++) begin
      in_addr[i] = 32'h10 + 32'(4 * i); in_mode[i] = 0; in_wdata[i] = 0;
    end
    in_we = 0;
    in_req = 3'b111;
    for (int c = 0; c < 6; c++) begin
      step(0, 0);
      chk($sformatf("rr%0d_gnt", c), 32'(snap_gnt), 32'(rr_exp[c]));
      chk($sformatf("rr%0d_prio", c), 32'(snap_pgnt), 32'd1);
    end

    // Load on ch1 with reset asserted at the following edge: response dropped.
    set_single(1, 0, 32'h10, 0, 0);
    step(0, 1);
    chk("rstmid_gnt", 32'(snap_gnt), 32'b010);
    in_req = 3'b111;
    step(1, 0);
    chk("rstmid_rvalid", 32'(snap_rv), 32'd0);
    chk("rstmid_gnt_in_reset", 32'(snap_gnt), 32'd0);
    step(0, 0);
    chk("rstmid_after_gnt", 32'(snap_gnt), 32'b001);

    // Randomised traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      in_req = 3'($urandom_range(0, 7));
      in_we  = 3'($urandom_range(0, 7));
      for (int i = 0; i < NCH; i++) begin
        in_addr[i]  = 32'($urandom_range(0, 255));
        in_wdata[i] = $urandom;
        in_mode[i]  = 3'($urandom_range(0, 7));
      end
      step(0, 0);
    end
    in_req = 0;
    step(0, 0);
    step(0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/kanade_mem_arbiter.md
Name: kanade_mem_arbiter

Overview:
- Parametrised N-channel arbiter in front of the single-port system RAM (port A, synchronous read, 1-cycle latency).
- Replaces the fixed two-way fetch/data address mux. Any number of requesters (fetch, load/store, DMA, debug) share the port, one access per cycle.
- Generates byte enables and lane-shifted store data.
- Returns load data aligned and zero- or sign-extended per access mode, so the writeback stage no longer does extraction.

Parameters:
- NUM_CH, 2, number of requester channels (>=1); channel 0 is the lowest index.
- ADDR_W, 32, byte address width per channel.
- PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  synchronous reset, active low, sampled on rising clk.
- ch_req  input  NUM_CH  per-channel request; held high until granted.
- ch_we  input  NUM_CH  1 = store, 0 = load.
- ch_addr  input  NUM_CH*ADDR_W  byte addresses; channel i is at [i*ADDR_W +: ADDR_W].
- ch_wdata  input  NUM_CH*32  store data, right-justified.
- ch_mode  input  NUM_CH*3  access mode: 0 word, 1 byte unsigned, 2 byte signed, 3 hword unsigned, 4 hword signed; 5-7 treated as word.
- ch_gnt  output  NUM_CH  one-hot; the request is accepted this cycle.
- ch_rvalid  output  NUM_CH  one-hot; load data valid on ch_rdata.
- ch_err  output  NUM_CH  misaligned-access pulse.
- ch_rdata  output  32  aligned, extended load data (shared by all channels).
- mem_addr  output  ADDR_W-2  word address to RAM.
- mem_wdata  output  32  lane-shifted store data.
- mem_byteen  output  4  byte enables.
- mem_wren  output  1  RAM write enable.
- mem_q  input  32  RAM read data, valid one cycle after the address.

Behaviour:
- Grant:
  - Combinational from ch_req and the arbitration state.
  - At most one ch_gnt bit high.
  - No grant while reset_n is low.
  - With no request: ch_gnt = 0, mem_wren = 0, mem_byteen = 4'b1111, mem_addr = 0.
- Round-robin (PRIO_MODE=0):
  - Register last_gnt holds the index of the last granted channel; reset value NUM_CH-1, so channel 0 wins first.
  - Search starts at last_gnt+1 and wraps modulo NUM_CH.
  - last_gnt updates only on a cycle with a grant.
  - Fixed mode ignores last_gnt.
- Memory drive in the grant cycle:
  - mem_addr = addr[ADDR_W-1:2] of the granted channel.
  - Lanes are little-endian: lane k = bits [8k+7:8k].
  - Byte store: byteen = 4'b0001 << a[1:0]; wdata = wdata << 8*a[1:0].
  - Hword store: byteen = 4'b0011 << {a[1],1'b0}; wdata shifted by 16*a[1].
  - Word store: byteen = 4'b1111; wdata unshifted.
  - mem_wren = granted & we & aligned.
- Alignment:
  - Hword requires a[0]=0. Word requires a[1:0]=0. Byte is always aligned.
  - Misaligned access is still granted (the requester is released), but no RAM write occurs.
  - One cycle later ch_err[i] pulses for one cycle.
  - No ch_rvalid is produced for a misaligned access.
- Response pipeline:
  - On a granted aligned load, register the channel index, a[1:0] and mode.
  - In the next cycle: ch_rvalid[i] = 1 for one cycle; ch_rdata = extracted mem_q.
  - Byte extraction: lane a[1:0]. Hword extraction: lanes {a[1],0} and {a[1],1}.
  - Zero- or sign-extension per mode.
  - Stores produce no rvalid.
- Throughput:
  - Back-to-back grants every cycle are allowed.
  - The response for access n appears in the same cycle as the grant of access n+1.
- Registered outputs ch_rvalid, ch_err and ch_rdata reset to 0. last_gnt resets to NUM_CH-1.
- Reset mid-operation: a load granted in the cycle reset is asserted is dropped; no rvalid follows.
- Changing the inputs of a request that has not yet been granted is legal. The arbiter samples only at the grant cycle.
- When ch_rvalid is 0, ch_rdata holds its last value.

Test Plan:
- NUM_CH=2, RR; reset; ch0 word store to 0x10 of 0xDEADBEEF, then ch1 word load from 0x10 -> ch1 rvalid in the cycle after its grant; rdata = 0xDEADBEEF.
- Byte store 0x000000A5 to 0x13 -> byteen = 4'b1000, wdata = 0xA5000000. Then load 0x13 in mode 2 -> rdata = 0xFFFFFFA5; in mode 1 -> 0x000000A5.
- Hword store 0x8001 to 0x22 -> byteen = 4'b1100. Load 0x22 in mode 4 -> rdata = 0xFFFF8001.
- NUM_CH=3, RR; all req held high for 6 cycles -> grant order 0,1,2,0,1,2. With PRIO_MODE=1 -> grants 0 every cycle.
- Word load from 0x11 -> granted; mem_wren = 0; ch_err pulses 1 cycle later; no rvalid. Hword store to 0x05 -> no write; RAM is unchanged.
- ch1 load granted, with reset_n low on the following edge -> no rvalid; after reset, last_gnt = NUM_CH-1 and the next simultaneous request goes to ch0.
